// File: rtl/uart_port_ctrl.sv
// rtl/uart_port_ctrl.sv - port-mapped UART controller: TX/RX FIFOs, line-setting
// registers, baud divisor and edge-set/ack-clear interrupt beside tx/rx engines.
module uart_port_ctrl #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] PORT_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] port_id,
  input  logic [15:0] out_port,
  input  logic        write_strobe,
  input  logic        read_strobe,
  output logic [15:0] in_port,
  output logic        interrupt,
  input  logic        int_ack,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  input  logic        txrdy,
  input  logic [7:0]  rx_data,
  input  logic        rxrdy,
  input  logic        ferr,
  input  logic        perr,
  input  logic        ovf,
  output logic        rx_clr,
  output logic        eight,
  output logic        pen,
  output logic        ohel,
  output logic [18:0] k
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [15:0] P_DATA  = PORT_BASE;
  localparam logic [15:0] P_STAT  = PORT_BASE + 16'd1;
  localparam logic [15:0] P_CTRL  = PORT_BASE + 16'd2;
  localparam logic [15:0] P_CLR   = PORT_BASE + 16'd3;

  typedef enum logic {T_IDLE, T_WAIT} t_state_e;
  typedef enum logic {R_IDLE, R_CLR}  r_state_e;

  logic [7:0]  r_tx_mem [DEPTH];
  logic [10:0] r_rx_mem [DEPTH];
  logic [AW:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [8:0]  r_ctrl;
  logic [18:0] r_k;
  logic [7:0]  r_tx_data;
  logic        r_tx_load, r_rx_clr, r_rx_ovr, r_tx_ovf, r_cond_d, r_int;
  t_state_e    r_t_state;
  r_state_e    r_r_state;

  logic        w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_clr;
  logic        w_data_wr, w_ctrl_wr, w_clr_wr;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_tx_pop, w_tx_push, w_tx_ovf_set;
  logic        w_rx_cap, w_rx_pop, w_rx_push, w_rx_ovr_set;
  logic        w_cond;
  logic [15:0] w_status;
  logic        w_unused_ok;

  assign w_sel_data = (port_id == P_DATA);
  assign w_sel_stat = (port_id == P_STAT);
  assign w_sel_ctrl = (port_id == P_CTRL);
  assign w_sel_clr  = (port_id == P_CLR);
  assign w_data_wr  = write_strobe & w_sel_data;
  assign w_ctrl_wr  = write_strobe & w_sel_ctrl;
  assign w_clr_wr   = write_strobe & w_sel_clr;

  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_tx_pop     = (r_t_state == T_IDLE) & ~w_tx_empty & txrdy;
  assign w_tx_push    = w_data_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set = w_data_wr & w_tx_full & ~w_tx_pop;

  assign w_rx_cap     = (r_r_state == R_IDLE) & rxrdy;
  assign w_rx_pop     = read_strobe & w_sel_data & ~w_rx_empty;
  assign w_rx_push    = w_rx_cap & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr_set = w_rx_cap & w_rx_full & ~w_rx_pop;

  assign w_cond   = (r_ctrl[7] & ~w_rx_empty) | (r_ctrl[8] & w_tx_empty);
  assign w_status = {7'b0, r_tx_ovf, r_rx_ovr, 3'b0, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
  assign w_unused_ok = &{1'b0, out_port[15:9]};

  function automatic logic [18:0] baud_to_k(input logic [3:0] baud);
    case (baud)
      4'd0:    baud_to_k = 19'd333_333;
      4'd1:    baud_to_k = 19'd83_333;
      4'd2:    baud_to_k = 19'd41_667;
      4'd3:    baud_to_k = 19'd20_833;
      4'd5:    baud_to_k = 19'd5_208;
      4'd6:    baud_to_k = 19'd2_604;
      4'd7:    baud_to_k = 19'd1_736;
      4'd8:    baud_to_k = 19'd868;
      4'd9:    baud_to_k = 19'd434;
      4'd10:   baud_to_k = 19'd217;
      4'd11:   baud_to_k = 19'd109;
      default: baud_to_k = 19'd10_417;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= out_port[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= {ovf, perr, ferr, rx_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_ovr <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
      if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
      if (w_tx_ovf_set)               r_tx_ovf <= 1'b1;
      else if (w_clr_wr & out_port[8]) r_tx_ovf <= 1'b0;
      if (w_rx_ovr_set)               r_rx_ovr <= 1'b1;
      else if (w_clr_wr & out_port[7]) r_rx_ovr <= 1'b0;
    end
  end

  // k follows the value being written so it is valid one cycle after the control write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 9'h014;
      r_k    <= 19'd10_417;
    end else begin
      if (w_ctrl_wr) r_ctrl <= out_port[8:0];
      r_k <= baud_to_k(w_ctrl_wr ? out_port[3:0] : r_ctrl[3:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_t_state <= T_IDLE;
      r_tx_load <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_load <= 1'b0;
      case (r_t_state)
        T_IDLE: if (w_tx_pop) begin
          r_tx_load <= 1'b1;
          r_tx_data <= r_tx_mem[r_tx_rd[AW-1:0]];
          r_t_state <= T_WAIT;
        end
        T_WAIT: if (!txrdy) r_t_state <= T_IDLE;
        default: r_t_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r_state <= R_IDLE;
      r_rx_clr  <= 1'b0;
    end else begin
      r_rx_clr <= 1'b0;
      case (r_r_state)
        R_IDLE: if (w_rx_cap) begin
          r_rx_clr  <= 1'b1;
          r_r_state <= R_CLR;
        end
        R_CLR: if (!rxrdy) r_r_state <= R_IDLE;
        default: r_r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cond_d <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      r_cond_d <= w_cond;
      if (w_cond & ~r_cond_d) r_int <= 1'b1;
      else if (int_ack)       r_int <= 1'b0;
    end
  end

  always_comb begin
    in_port = 16'h0000;
    if (w_sel_data && !w_rx_empty) in_port = {5'b0, r_rx_mem[r_rx_rd[AW-1:0]]};
    else if (w_sel_stat)           in_port = w_status;
    else if (w_sel_ctrl)           in_port = {7'b0, r_ctrl};
  end

  assign interrupt = r_int;
  assign tx_load   = r_tx_load;
  assign tx_data   = r_tx_data;
  assign rx_clr    = r_rx_clr;
  assign eight     = r_ctrl[4];
  assign pen       = r_ctrl[5];
  assign ohel      = r_ctrl[6];
  assign k         = r_k;

endmodule
